chirp_frame_sequencer: RTL and testbench

- Parametrised chirp/frame framing and buffering stage between the read-side beat stream and the processing/write path of the RSP S2 prep chain.
- Replaces the fixed 1023-beat chirp-last counter with programmable beats-per-chirp and chirps-per-frame.
- Tags every beat with sop/eop/frame-last, buffers beats in an internal FIFO with valid/ready backpressure, and reports frame completion with a start/end handshake.

---
 rtl/chirp_frame_sequencer.sv | 217 +++++++++++++++++++++
 tb/tb_chirp_frame_sequencer.sv | 370 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/chirp_frame_sequencer.sv
// Chirp/frame sequencer: tags a beat stream with sop/eop/frame-last using
// programmable beats-per-chirp and chirps-per-frame, buffers the tagged beats
// in a first-word-fall-through FIFO and reports frame completion.
// Optional feature: define CHIRP_FRAME_ABORT_EN to add the i_abort input.
module chirp_frame_sequencer #(
    parameter int unsigned DATA_W     = 128,
    parameter int unsigned FIFO_DEPTH = 16,
    parameter int unsigned BEAT_W     = 13,
    parameter int unsigned CHP_W      = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_start,
`ifdef CHIRP_FRAME_ABORT_EN
    input  logic              i_abort,
`endif
    input  logic [BEAT_W-1:0] cfg_beats,
    input  logic [CHP_W-1:0]  cfg_chirps,
    input  logic [DATA_W-1:0] s_data,
    input  logic              s_valid,
    output logic              s_ready,
    output logic [DATA_W-1:0] m_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic              m_sop,
    output logic              m_eop,
    output logic              m_flast,
    output logic              o_busy,
    output logic              o_end,
    output logic              o_cfg_err,
    output logic [CHP_W-1:0]  o_chirp_cnt
);

    localparam int unsigned PTR_W   = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W   = PTR_W + 1;
    localparam int unsigned ENTRY_W = DATA_W + 3;

    localparam logic [CNT_W-1:0] DepthCnt = CNT_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDrain,
        StDone
    } state_e;

    state_e state_q, state_d;

    // Latched frame configuration and position counters
    logic [BEAT_W-1:0] beats_q, beats_d;
    logic [CHP_W-1:0]  chirps_q, chirps_d;
    logic [BEAT_W-1:0] beat_cnt_q, beat_cnt_d;
    logic [CHP_W-1:0]  chirp_cnt_q, chirp_cnt_d;
    logic              cfg_err_q, cfg_err_d;

    // FIFO storage and bookkeeping
    logic [ENTRY_W-1:0] mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]   count_q;
    logic [ENTRY_W-1:0] wr_entry;
    logic [ENTRY_W-1:0] rd_entry;

    logic abort;
    logic push;
    logic pop;
    logic flush;
    logic tag_sop;
    logic tag_eop;
    logic tag_flast;
    logic cfg_ok;

`ifdef CHIRP_FRAME_ABORT_EN
    assign abort = i_abort;
`else
    assign abort = 1'b0;
`endif

    // Input handshake: ready depends on registered occupancy only, so a pop in
    // the same cycle never frees a slot combinationally.
    assign s_ready = (state_q == StRun) && (count_q < DepthCnt);
    assign push    = s_valid && s_ready && !abort;
    assign m_valid = (count_q != '0);
    assign pop     = m_valid && m_ready;

    assign cfg_ok    = (cfg_beats != '0) && (cfg_chirps != '0);
    assign tag_sop   = (beat_cnt_q == '0);
    assign tag_eop   = (beat_cnt_q == beats_q - BEAT_W'(1));
    assign tag_flast = tag_eop && (chirp_cnt_q == chirps_q - CHP_W'(1));

    assign wr_entry = {tag_flast, tag_eop, tag_sop, s_data};
    assign rd_entry = mem_q[rd_ptr_q];

    // Outputs are forced to zero whenever no beat is presented
    assign m_data  = m_valid ? rd_entry[DATA_W-1:0] : '0;
    assign m_sop   = m_valid & rd_entry[DATA_W];
    assign m_eop   = m_valid & rd_entry[DATA_W+1];
    assign m_flast = m_valid & rd_entry[DATA_W+2];

    assign o_busy      = (state_q == StRun) || (state_q == StDrain);
    assign o_end       = (state_q == StDone);
    assign o_cfg_err   = cfg_err_q;
    assign o_chirp_cnt = chirp_cnt_q;

    // Next-state logic for the frame FSM and its counters
    always_comb begin
        state_d     = state_q;
        beats_d     = beats_q;
        chirps_d    = chirps_q;
        beat_cnt_d  = beat_cnt_q;
        chirp_cnt_d = chirp_cnt_q;
        cfg_err_d   = 1'b0;
        flush       = 1'b0;

        unique case (state_q)
            StIdle: begin
                // Start takes priority over abort here; abort is meaningless in IDLE
                if (i_start) begin
                    if (cfg_ok) begin
                        beats_d     = cfg_beats;
                        chirps_d    = cfg_chirps;
                        beat_cnt_d  = '0;
                        chirp_cnt_d = '0;
                        state_d     = StRun;
                    end else begin
                        cfg_err_d = 1'b1;
                    end
                end
            end
            StRun: begin
                if (abort) begin
                    flush       = 1'b1;
                    beat_cnt_d  = '0;
                    chirp_cnt_d = '0;
                    state_d     = StDone;
                end else if (push) begin
                    if (tag_eop) begin
                        beat_cnt_d  = '0;
                        chirp_cnt_d = chirp_cnt_q + CHP_W'(1);
                        if (tag_flast) begin
                            state_d = StDrain;
                        end
                    end else begin
                        beat_cnt_d = beat_cnt_q + BEAT_W'(1);
                    end
                end
            end
            StDrain: begin
                if (abort) begin
                    flush       = 1'b1;
                    beat_cnt_d  = '0;
                    chirp_cnt_d = '0;
                    state_d     = StDone;
                end else if (count_q == '0) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // FSM, configuration and counter registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            beats_q     <= '0;
            chirps_q    <= '0;
            beat_cnt_q  <= '0;
            chirp_cnt_q <= '0;
            cfg_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            beats_q     <= beats_d;
            chirps_q    <= chirps_d;
            beat_cnt_q  <= beat_cnt_d;
            chirp_cnt_q <= chirp_cnt_d;
            cfg_err_q   <= cfg_err_d;
        end
    end

    // FIFO pointers and occupancy; push+pop leaves the count unchanged
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            if (push && !pop) begin
                count_q <= count_q + CNT_W'(1);
            end else if (!push && pop) begin
                count_q <= count_q - CNT_W'(1);
            end
        end
    end

    // FIFO storage; contents need no reset since m_* are gated by m_valid
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= wr_entry;
        end
    end

endmodule

// File: tb/tb_chirp_frame_sequencer.sv
// Self-checking bench for chirp_frame_sequencer: randomized traffic against a
// frame-level reference model (beat indices, occupancy, phase), plus literal
// expectations for the directed scenarios. Honours CHIRP_FRAME_ABORT_EN.
module tb_chirp_frame_sequencer;

    localparam int DATA_W     = 128;
    localparam int FIFO_DEPTH = 16;
    localparam int BEAT_W     = 13;
    localparam int CHP_W      = 10;

    localparam int PIdle  = 0;
    localparam int PRun   = 1;
    localparam int PDrain = 2;
    localparam int PDone  = 3;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              i_start = 1'b0;
`ifdef CHIRP_FRAME_ABORT_EN
    logic              i_abort = 1'b0;
`endif
    logic [BEAT_W-1:0] cfg_beats = '0;
    logic [CHP_W-1:0]  cfg_chirps = '0;
    logic [DATA_W-1:0] s_data = '0;
    logic              s_valid = 1'b0;
    logic              s_ready;
    logic [DATA_W-1:0] m_data;
    logic              m_valid;
    logic              m_ready = 1'b0;
    logic              m_sop;
    logic              m_eop;
    logic              m_flast;
    logic              o_busy;
    logic              o_end;
    logic              o_cfg_err;
    logic [CHP_W-1:0]  o_chirp_cnt;

    chirp_frame_sequencer #(
        .DATA_W     (DATA_W),
        .FIFO_DEPTH (FIFO_DEPTH),
        .BEAT_W     (BEAT_W),
        .CHP_W      (CHP_W)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_start     (i_start),
`ifdef CHIRP_FRAME_ABORT_EN
        .i_abort     (i_abort),
`endif
        .cfg_beats   (cfg_beats),
        .cfg_chirps  (cfg_chirps),
        .s_data      (s_data),
        .s_valid     (s_valid),
        .s_ready     (s_ready),
        .m_data      (m_data),
        .m_valid     (m_valid),
        .m_ready     (m_ready),
        .m_sop       (m_sop),
        .m_eop       (m_eop),
        .m_flast     (m_flast),
        .o_busy      (o_busy),
        .o_end       (o_end),
        .o_cfg_err   (o_cfg_err),
        .o_chirp_cnt (o_chirp_cnt)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    // ---------------- reference model ----------------
    typedef struct packed {
        logic              flast;
        logic              eop;
        logic              sop;
        logic [DATA_W-1:0] d;
    } beat_t;

    beat_t exp_q[$];
    int    ph    = PIdle;
    int    m_acc = 0;   // beats accepted in the current frame
    int    m_pop = 0;   // beats delivered in the current frame
    int    m_b   = 0;
    int    m_c   = 0;
    bit    m_err = 1'b0;

    initial forever begin
        int    occ0;
        bit    push, pop, ab;
        beat_t b;
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            ph = PIdle; m_acc = 0; m_pop = 0; m_err = 1'b0;
            exp_q.delete();
        end else begin
`ifdef CHIRP_FRAME_ABORT_EN
            ab = i_abort;
`else
            ab = 1'b0;
`endif
            occ0  = m_acc - m_pop;
            push  = (ph == PRun) && (occ0 < FIFO_DEPTH) && s_valid;
            pop   = (occ0 > 0) && m_ready;
            m_err = 1'b0;
            if (pop) begin
                void'(exp_q.pop_front());
                m_pop++;
            end
            if (push) begin
                b.d     = s_data;
                b.sop   = (m_acc % m_b) == 0;
                b.eop   = (m_acc % m_b) == m_b - 1;
                b.flast = m_acc == m_b * m_c - 1;
                exp_q.push_back(b);
                m_acc++;
            end
            case (ph)
                PIdle: begin
                    if (i_start) begin
                        if (cfg_beats != 0 && cfg_chirps != 0) begin
                            m_b = int'(cfg_beats); m_c = int'(cfg_chirps);
                            m_acc = 0; m_pop = 0; exp_q.delete();
                            ph = PRun;
                        end else begin
                            m_err = 1'b1;
                        end
                    end
                end
                PRun, PDrain: begin
                    if (ab) begin
                        m_acc = 0; m_pop = 0; exp_q.delete();
                        ph = PDone;
                    end else if (ph == PRun && m_acc == m_b * m_c) begin
                        ph = PDrain;
                    end else if (ph == PDrain && occ0 == 0) begin
                        ph = PDone;
                    end
                end
                default: ph = PIdle;
            endcase
        end
    end

    // ---------------- compare / monitor ----------------
    int          cyc = 0;
    int          out_cnt = 0;
    int          push_cnt = 0;
    int          end_cnt = 0;
    int          err_cnt = 0;
    int          end_cyc = 0;
    int          flast_pop_cyc = 0;
    logic [63:0] sop_mask = '0;
    logic [63:0] eop_mask = '0;
    logic [63:0] flast_mask = '0;

    initial forever begin
        int occ;
        @(negedge clk);
        cyc++;
        occ = m_acc - m_pop;
        chk("s_ready", s_ready, (ph == PRun) && (occ < FIFO_DEPTH));
        chk("m_valid", m_valid, occ > 0);
        chk("o_busy", o_busy, (ph == PRun) || (ph == PDrain));
        chk("o_end", o_end, ph == PDone);
        chk("o_cfg_err", o_cfg_err, m_err);
        chk("o_chirp_cnt", o_chirp_cnt, (m_b == 0) ? 0 : m_acc / m_b);
        if (exp_q.size() > 0) begin
            chk("m_data", m_data, exp_q[0].d);
            chk("m_sop", m_sop, exp_q[0].sop);
            chk("m_eop", m_eop, exp_q[0].eop);
            chk("m_flast", m_flast, exp_q[0].flast);
        end
        if (!rst_n) chk("m_data_in_reset", m_data, 0);
        if (m_valid && m_ready) begin
            if (out_cnt < 64) begin
                sop_mask[out_cnt]   = m_sop;
                eop_mask[out_cnt]   = m_eop;
                flast_mask[out_cnt] = m_flast;
            end
            if (m_flast) flast_pop_cyc = cyc;
            out_cnt++;
        end
        if (s_valid && s_ready) push_cnt++;
        if (o_end) begin
            end_cnt++;
            end_cyc = cyc;
        end
        if (o_cfg_err) err_cnt++;
    end

    // ---------------- random data/handshake driver ----------------
    int vprob = 0;
    int rprob = 0;

    initial forever begin
        @(posedge clk);
        #1;
        s_valid = ($urandom_range(99) < vprob);
        m_ready = ($urandom_range(99) < rprob);
        s_data  = {$urandom(), $urandom(), $urandom(), $urandom()};
    end

    // ---------------- directed sequences ----------------
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clr_mon();
        out_cnt = 0; push_cnt = 0;
        sop_mask = '0; eop_mask = '0; flast_mask = '0;
    endtask

    task automatic do_start(input int b, input int c);
        cfg_beats  = BEAT_W'(b);
        cfg_chirps = CHP_W'(c);
        i_start    = 1'b1;
        tick(1);
        i_start    = 1'b0;
    endtask

    task automatic wait_end(input string name, input int limit);
        int e0 = end_cnt;
        int n  = 0;
        while (end_cnt == e0 && n < limit) begin
            tick(1);
            n++;
        end
        chk({name, "_end_seen"}, end_cnt != e0, 1);
    endtask

    task automatic wait_push(input string name, input int cnt, input int limit);
        int n = 0;
        while (push_cnt < cnt && n < limit) begin
            tick(1);
            n++;
        end
        chk({name, "_push_reached"}, push_cnt >= cnt, 1);
    endtask

    initial begin
        int e0;
        int r0;
        tick(2);
        chk("rst_busy", o_busy, 0);
        chk("rst_m_valid", m_valid, 0);
        chk("rst_s_ready", s_ready, 0);
        chk("rst_chirp_cnt", o_chirp_cnt, 0);
        rst_n = 1'b1;
        tick(3);

        // 4 beats x 2 chirps, continuous flow
        clr_mon(); vprob = 100; rprob = 100; e0 = end_cnt;
        do_start(4, 2);
        wait_end("t1", 200);
        chk("t1_beats_out", out_cnt, 8);
        chk("t1_sop_mask", sop_mask, 64'h11);
        chk("t1_eop_mask", eop_mask, 64'h88);
        chk("t1_flast_mask", flast_mask, 64'h80);
        chk("t1_end_latency", end_cyc - flast_pop_cyc, 2);
        chk("t1_chirp_cnt", o_chirp_cnt, 2);
        tick(4);
        chk("t1_end_once", end_cnt - e0, 1);
        chk("t1_chirp_hold", o_chirp_cnt, 2);

        // Back-pressure: 32 x 1 with sink stalled fills exactly FIFO_DEPTH
        clr_mon(); vprob = 100; rprob = 0;
        do_start(32, 1);
        tick(30);
        chk("t2_accepted", push_cnt, 16);
        chk("t2_s_ready_full", s_ready, 0);
        rprob = 100;
        wait_end("t2", 400);
        chk("t2_beats_out", out_cnt, 32);

        // One beat per chirp
        clr_mon(); vprob = 60; rprob = 60;
        do_start(1, 3);
        wait_end("t3", 300);
        chk("t3_beats_out", out_cnt, 3);
        chk("t3_sop_mask", sop_mask, 64'h7);
        chk("t3_eop_mask", eop_mask, 64'h7);
        chk("t3_flast_mask", flast_mask, 64'h4);
        chk("t3_chirp_cnt", o_chirp_cnt, 3);

        // Illegal configurations
        e0 = end_cnt; r0 = err_cnt;
        do_start(0, 5);
        tick(4);
        chk("t4_cfg_err_pulses", err_cnt - r0, 1);
        chk("t4_busy", o_busy, 0);
        chk("t4_s_ready", s_ready, 0);
        do_start(4, 0);
        tick(4);
        chk("t4_cfg_err_pulses2", err_cnt - r0, 2);
        chk("t4_no_end", end_cnt - e0, 0);

        // Random 7 x 5 with an ignored second start
        clr_mon(); vprob = 50; rprob = 50;
        do_start(7, 5);
        wait_push("t5", 12, 500);
        do_start(3, 2);
        wait_end("t5", 3000);
        chk("t5_beats_out", out_cnt, 35);
        chk("t5_sop_mask", sop_mask, 64'h10204081);
        chk("t5_eop_mask", eop_mask, 64'h408102040);
        chk("t5_flast_mask", flast_mask, 64'h400000000);
        chk("t5_chirp_cnt", o_chirp_cnt, 5);

        // Reset mid-frame
        clr_mon(); e0 = end_cnt;
        do_start(7, 5);
        wait_push("t6", 20, 1000);
        rst_n = 1'b0;
        tick(1);
        chk("t6_rst_busy", o_busy, 0);
        chk("t6_rst_m_valid", m_valid, 0);
        chk("t6_rst_chirp_cnt", o_chirp_cnt, 0);
        tick(2);
        rst_n = 1'b1;
        tick(6);
        chk("t6_no_end", end_cnt - e0, 0);
        chk("t6_idle", o_busy, 0);

`ifdef CHIRP_FRAME_ABORT_EN
        // Abort after 10 beats, then a clean frame
        clr_mon(); vprob = 50; rprob = 30; e0 = end_cnt;
        do_start(7, 5);
        wait_push("t7", 10, 500);
        i_abort = 1'b1;
        tick(1);
        i_abort = 1'b0;
        chk("t7_m_valid_flushed", m_valid, 0);
        chk("t7_end_now", o_end, 1);
        tick(3);
        chk("t7_end_once", end_cnt - e0, 1);
        chk("t7_idle", o_busy, 0);
        i_abort = 1'b1;
        tick(1);
        i_abort = 1'b0;
        tick(3);
        chk("t7_idle_abort_noop", end_cnt - e0, 1);
        clr_mon(); rprob = 50;
        i_abort = 1'b1;
        do_start(7, 5);
        i_abort = 1'b0;
        wait_end("t7b", 3000);
        chk("t7b_beats_out", out_cnt, 35);
        chk("t7b_chirp_cnt", o_chirp_cnt, 5);
`endif

        tick(5);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, passed %0d of %0d", n_pass, n_checks);
        $fatal(1);
    end

endmodule
